// File: rtl/tomasulo_pkg.sv
// Shared core types and constants: halt FSM states, halting encodings, default tohost address.
// No logic, only declarations.
package tomasulo_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } halt_state_e;

  localparam logic [31:0] INSTR_ECALL         = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK        = 32'h0010_0073;
  localparam logic [31:0] HALT_CODE_WDOG      = 32'hDEAD_0001;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear has priority, holds at all-ones instead of wrapping.
// Latency 1 cycle from clear/enable to count; no flow control.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/commit_halt_monitor.sv
// Detects program termination at commit, stalls fetch, waits for drain, raises sticky done.
// Trigger-to-done >= 2 cycles, all outputs registered; optional watchdog via HALT_WATCHDOG_EN.
module commit_halt_monitor
  import tomasulo_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter int              WDOG_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_instr,
  input  logic             st_commit_valid,
  input  logic [XLEN-1:0]  st_commit_addr,
  input  logic [XLEN-1:0]  st_commit_data,
  input  logic             rob_empty,
  input  logic             sb_empty,
  output logic             fetch_stall,
  output logic             done,
  output logic [XLEN-1:0]  halt_code,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  halt_state_e state;
  logic        is_run;
  logic        instr_trig;
  logic        st_trig;
  logic        wdog_fire;

  assign is_run     = (state == RUN);
  assign instr_trig = commit_valid &&
                      ((commit_instr == INSTR_ECALL) || (commit_instr == INSTR_EBREAK));
  assign st_trig    = st_commit_valid && (st_commit_addr == TOHOST_ADDR);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .clear (reset),
    .en    (state != DONE),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .clear (reset),
    .en    (is_run && commit_valid),
    .count (instret_count)
  );

`ifdef HALT_WATCHDOG_EN
  logic [31:0] idle_cnt;

  sat_counter #(.W(32)) u_idle (
    .clk   (clk),
    .clear (reset || (is_run && commit_valid)),
    .en    (is_run),
    .count (idle_cnt)
  );

  // Fires on the edge where the idle count would reach WDOG_CYCLES.
  assign wdog_fire = is_run && !commit_valid && (idle_cnt == 32'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_fire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fetch_stall <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      halt_code   <= '0;
    end else begin
      case (state)
        RUN: begin
          // A tohost store outranks an ECALL/EBREAK retiring in the same cycle.
          if (st_trig) begin
            state       <= DRAIN;
            fetch_stall <= 1'b1;
            halt_code   <= st_commit_data;
          end else if (instr_trig) begin
            state       <= DRAIN;
            fetch_stall <= 1'b1;
            halt_code   <= (commit_instr == INSTR_EBREAK) ? XLEN'(1) : XLEN'(0);
          end else if (wdog_fire) begin
            state       <= DONE;
            fetch_stall <= 1'b1;
            done        <= 1'b1;
            timeout     <= 1'b1;
            halt_code   <= XLEN'(HALT_CODE_WDOG);
          end
        end
        DRAIN: begin
          if (rob_empty && sb_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_halt_monitor.sv
// Self-checking bench for commit_halt_monitor: directed scenarios plus randomized runs vs a reference model.
// Watchdog scenario follows HALT_WATCHDOG_EN.
module tb_commit_halt_monitor;

  localparam int          WDOG   = 8;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, commit_valid = 1'b0, st_commit_valid = 1'b0;
  logic [31:0] commit_instr = '0, st_commit_addr = '0, st_commit_data = '0;
  logic        rob_empty = 1'b1, sb_empty = 1'b1;
  logic        fetch_stall, done, timeout;
  logic [31:0] halt_code, cycle_count, instret_count;

  commit_halt_monitor #(.XLEN(32), .CNT_W(32), .TOHOST_ADDR(TOHOST), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_instr(commit_instr),
    .st_commit_valid(st_commit_valid), .st_commit_addr(st_commit_addr),
    .st_commit_data(st_commit_data), .rob_empty(rob_empty), .sb_empty(sb_empty),
    .fetch_stall(fetch_stall), .done(done), .halt_code(halt_code), .timeout(timeout),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  logic        s_reset = 1'b1;
  logic        s_stall, s_done, s_timeout;
  logic [31:0] s_code;
  logic [3:0]  s_cycle, s_instret;

  commit_halt_monitor #(.XLEN(32), .CNT_W(4), .TOHOST_ADDR(TOHOST), .WDOG_CYCLES(1000)) u_small (
    .clk(clk), .reset(s_reset), .commit_valid(1'b1), .commit_instr(NOP),
    .st_commit_valid(1'b0), .st_commit_addr(32'h0), .st_commit_data(32'h0),
    .rob_empty(1'b1), .sb_empty(1'b1), .fetch_stall(s_stall), .done(s_done),
    .halt_code(s_code), .timeout(s_timeout), .cycle_count(s_cycle), .instret_count(s_instret)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: phase 0 running, 1 halted waiting for drain, 2 finished.
  int          m_phase = 0;
  logic        m_stall = 0, m_done = 0, m_to = 0;
  logic [31:0] m_code = 0, m_cyc = 0, m_ins = 0;
  int          m_idle = 0;

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_edge();
    bit st_hit, in_hit;
    if (reset) begin
      m_phase = 0; m_stall = 0; m_done = 0; m_to = 0;
      m_code = 0; m_cyc = 0; m_ins = 0; m_idle = 0;
    end else if (m_phase == 0) begin
      m_cyc  = inc_sat(m_cyc);
      if (commit_valid) m_ins = inc_sat(m_ins);
      st_hit = st_commit_valid && (st_commit_addr == TOHOST);
      in_hit = commit_valid && (commit_instr == ECALL || commit_instr == EBREAK);
      m_idle = commit_valid ? 0 : m_idle + 1;
      if (st_hit || in_hit) begin
        m_phase = 1; m_stall = 1;
        m_code  = st_hit ? st_commit_data : ((commit_instr == EBREAK) ? 32'd1 : 32'd0);
      end
`ifdef HALT_WATCHDOG_EN
      else if (m_idle == WDOG) begin
        m_phase = 2; m_stall = 1; m_done = 1; m_to = 1; m_code = 32'hDEAD_0001;
      end
`endif
    end else if (m_phase == 1) begin
      m_cyc = inc_sat(m_cyc);
      if (rob_empty && sb_empty) begin
        m_phase = 2; m_done = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    commit_valid = 0; commit_instr = NOP; st_commit_valid = 0;
    st_commit_addr = 0; st_commit_data = 0; rob_empty = 1; sb_empty = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({fetch_stall, done, timeout, halt_code, cycle_count, instret_count} !== 99'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b done=%b to=%b code=%h cyc=%0d ins=%0d, want all 0",
               fetch_stall, done, timeout, halt_code, cycle_count, instret_count);
    end
  endtask

  task automatic test_ecall();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      commit_valid = 1; commit_instr = NOP; step();
    end
    commit_instr = ECALL; step();
    vectors++;
    if (fetch_stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ecall_stall: got stall=%b done=%b, want stall=1 done=0", fetch_stall, done);
    end
    commit_valid = 0; step();
    vectors++;
    if (done !== 1'b1 || halt_code !== 32'd0 || instret_count !== 32'd11 || cycle_count !== 32'd12) begin
      errors++;
      $display("FAIL ecall_done: got done=%b code=%h ins=%0d cyc=%0d, want 1 0 11 12",
               done, halt_code, instret_count, cycle_count);
    end
    commit_valid = 1; commit_instr = EBREAK;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (done !== 1'b1 || halt_code !== 32'd0 || instret_count !== 32'd11 || cycle_count !== 32'd12) begin
      errors++;
      $display("FAIL ecall_frozen: got done=%b code=%h ins=%0d cyc=%0d, want 1 0 11 12",
               done, halt_code, instret_count, cycle_count);
    end
  endtask

  task automatic test_store_priority();
    do_reset();
    commit_valid = 1; commit_instr = EBREAK;
    st_commit_valid = 1; st_commit_addr = TOHOST; st_commit_data = 32'h2A;
    step();
    idle_inputs(); step();
    vectors++;
    if (done !== 1'b1 || halt_code !== 32'h2A || instret_count !== 32'd1) begin
      errors++;
      $display("FAIL store_priority: got done=%b code=%h ins=%0d, want 1 0000002a 1",
               done, halt_code, instret_count);
    end
  endtask

  task automatic test_drain_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1; commit_instr = NOP; step();
    end
    commit_instr = EBREAK; sb_empty = 0; step();
    commit_instr = ECALL;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (done !== 1'b0 || instret_count !== 32'd4 || halt_code !== 32'd1) begin
        errors++;
        $display("FAIL drain_hold[%0d]: got done=%b ins=%0d code=%h, want 0 4 1",
                 i, done, instret_count, halt_code);
      end
    end
    sb_empty = 1; step();
    vectors++;
    if (done !== 1'b1 || instret_count !== 32'd4 || halt_code !== 32'd1 || cycle_count !== m_cyc) begin
      errors++;
      $display("FAIL drain_release: got done=%b ins=%0d code=%h cyc=%0d, want 1 4 1 %0d",
               done, instret_count, halt_code, cycle_count, m_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    commit_valid = 1; commit_instr = EBREAK; sb_empty = 0; step();
    commit_valid = 0; step();
    reset = 1; step(); reset = 0;
    vectors++;
    if ({fetch_stall, done, timeout, halt_code, cycle_count, instret_count} !== 99'd0) begin
      errors++;
      $display("FAIL reset_in_drain: got stall=%b done=%b code=%h cyc=%0d ins=%0d, want all 0",
               fetch_stall, done, halt_code, cycle_count, instret_count);
    end
    sb_empty = 1; commit_valid = 1; commit_instr = ECALL; step(); step();
    reset = 1; idle_inputs(); step(); reset = 0;
    vectors++;
    if ({fetch_stall, done, timeout, halt_code, cycle_count, instret_count} !== 99'd0) begin
      errors++;
      $display("FAIL reset_in_done: got stall=%b done=%b code=%h cyc=%0d ins=%0d, want all 0",
               fetch_stall, done, halt_code, cycle_count, instret_count);
    end
    commit_valid = 1; commit_instr = NOP; step();
    vectors++;
    if (cycle_count !== 32'd1 || instret_count !== 32'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_count: got cyc=%0d ins=%0d done=%b, want 1 1 0",
               cycle_count, instret_count, done);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
`ifdef HALT_WATCHDOG_EN
    for (int i = 1; i <= 14; i++) begin
      commit_valid = (i == 7);
      step();
      vectors++;
      if (done !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL wdog_early[%0d]: got done=%b timeout=%b, want 0 0", i, done, timeout);
      end
    end
    commit_valid = 0; step();
    vectors++;
    if (done !== 1'b1 || timeout !== 1'b1 || fetch_stall !== 1'b1 || halt_code !== 32'hDEAD_0001) begin
      errors++;
      $display("FAIL wdog_fire: got done=%b to=%b stall=%b code=%h, want 1 1 1 dead0001",
               done, timeout, fetch_stall, halt_code);
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (timeout !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_wdog[%0d]: got timeout=%b done=%b, want 0 0", i, timeout, done);
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        commit_valid    = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 39))
          0:       commit_instr = ECALL;
          1:       commit_instr = EBREAK;
          default: commit_instr = $urandom;
        endcase
        st_commit_valid = ($urandom_range(0, 4) == 0);
        st_commit_addr  = ($urandom_range(0, 9) == 0) ? TOHOST : $urandom;
        st_commit_data  = $urandom;
        rob_empty       = ($urandom_range(0, 2) != 0);
        sb_empty        = ($urandom_range(0, 2) != 0);
        step();
        vectors++;
        if ({fetch_stall, done, timeout} !== {m_stall, m_done, m_to} || halt_code !== m_code) begin
          errors++;
          $display("FAIL rand_ctl ep%0d c%0d: got s/d/t=%b%b%b code=%h, want %b%b%b code=%h",
                   ep, c, fetch_stall, done, timeout, halt_code, m_stall, m_done, m_to, m_code);
        end
        vectors++;
        if (cycle_count !== m_cyc || instret_count !== m_ins) begin
          errors++;
          $display("FAIL rand_cnt ep%0d c%0d: got cyc=%0d ins=%0d, want cyc=%0d ins=%0d",
                   ep, c, cycle_count, instret_count, m_cyc, m_ins);
        end
      end
    end
  endtask

  task automatic test_saturation();
    s_reset = 1; @(posedge clk); #1; s_reset = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (s_cycle !== ((i > 15) ? 4'hF : 4'(i)) || s_instret !== ((i > 15) ? 4'hF : 4'(i))) begin
        errors++;
        $display("FAIL sat_count[%0d]: got cyc=%h ins=%h, want %h", i, s_cycle, s_instret,
                 (i > 15) ? 4'hF : 4'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_store_priority();
    test_drain_wait();
    test_reset_mid();
    test_watchdog();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
